control_sequencer: RTL and testbench



---
 rtl/control_sequencer.sv | 150 +++++++++++++++
 tb/tb_control_sequencer.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// control_sequencer: hardwired fetch/decode/execute step sequencer for the CPU datapath
//   in : clk, reset (async, active-low), run (fetch gate, T0 only), ir (opcode ir[31:27]), CON_FF (branch condition)
//   out: bus drivers, register-file selects, register loads, one-hot ALU selects,
//        memory/condition-register control, halted
module control_sequencer #(
  parameter int MEM_WAIT = 0,
  parameter int STEP_W = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic [31:0] ir,
  input  logic        CON_FF,
  output logic        HIout, LOout, Zhighout, Zlowout, PCout, MDRout, INout, Cout, MARout,
  output logic        Gra, Grb, Grc, Rin, Rout, BAout, PCSave,
  output logic        HIin, LOin, PCin, IRin, Zin, Yin, MARin, MDRin, CONin, OUT_Portin, IncPC,
  output logic        ADD, SUB, AND, OR, SHR, SHRA, SHL, ROR, ROL, MUL, DIV, NEG, NOT,
  output logic        Read, read_mem, write_mem, CON_RESET,
  output logic        halted
);
  typedef enum logic [1:0] {RST, FETCH, EXEC, HALT} state_t;
  localparam logic [STEP_W-1:0] T0 = STEP_W'(0), T1 = STEP_W'(1), T2 = STEP_W'(2), T3 = STEP_W'(3);
  localparam logic [STEP_W-1:0] T4 = STEP_W'(4), T5 = STEP_W'(5), T6 = STEP_W'(6), T7 = STEP_W'(7);
  localparam logic [STEP_W-1:0] WAIT_INIT = STEP_W'(MEM_WAIT);
  state_t state_q, state_d;
  logic [STEP_W-1:0] step_q, step_d, wait_q, wait_d, last, nxt;
  logic [4:0] op;
  logic is_ld, is_ldi, is_st, is_r, is_imm, is_md, is_nn, is_br, is_halt, mem, alu_en, add_fix;
  logic unused_ir;
  assign op = ir[31:27];
  assign unused_ir = ^ir[26:0];
  assign is_ld = op == 5'd0;
  assign is_ldi = op == 5'd1;
  assign is_st = op == 5'd2;
  assign is_r = op >= 5'd3 && op <= 5'd11;
  assign is_imm = op >= 5'd12 && op <= 5'd14;
  assign is_md = op == 5'd15 || op == 5'd16;
  assign is_nn = op == 5'd17 || op == 5'd18;
  assign is_br = op == 5'd19;
  assign is_halt = op == 5'd27;
  // final step of each instruction; nop, halt and undefined opcodes end at T2
  assign last = (is_ld || is_st) ? T7 :
                (is_md || is_br) ? T6 :
                (is_ldi || is_r || is_imm) ? T5 :
                (is_nn || op == 5'd21) ? T4 :
                (op >= 5'd20 && op <= 5'd25) ? T3 : T2;
  // steps that touch memory stretch by the wait counter
  assign mem = (state_q == FETCH && step_q == T1) ||
               (state_q == EXEC && ((is_ld && step_q == T6) || (is_st && step_q == T7)));
  assign nxt = step_q + STEP_W'(1);
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= RST;
      step_q <= T0;
      wait_q <= WAIT_INIT;
    end else begin
      state_q <= state_d;
      step_q <= step_d;
      wait_q <= wait_d;
    end
  always_comb begin
    state_d = state_q;
    step_d = step_q;
    wait_d = wait_q;
    if (state_q == RST) begin
      state_d = FETCH;
      step_d = T0;
      wait_d = WAIT_INIT;
    end else if (state_q != HALT && !(mem && wait_q != '0) && !(step_q == T0 && !run)) begin
      wait_d = WAIT_INIT;
      step_d = step_q == last ? T0 : nxt;
      state_d = step_q == last ? (is_halt ? HALT : FETCH) : (nxt >= T3 ? EXEC : FETCH);
    end else if (mem) wait_d = wait_q - STEP_W'(1);
  end
  always_comb begin
    {HIout, LOout, Zhighout, Zlowout, PCout, MDRout, INout, Cout, MARout} = '0;
    {Gra, Grb, Grc, Rin, Rout, BAout, PCSave} = '0;
    {HIin, LOin, PCin, IRin, Zin, Yin, MARin, MDRin, CONin, OUT_Portin, IncPC} = '0;
    {Read, read_mem, write_mem, CON_RESET, halted, alu_en, add_fix} = '0;
    // reset gates the decode so outputs drop the moment reset asserts
    if (reset)
      case (state_q)
        RST: CON_RESET = 1'b1;
        HALT: halted = 1'b1;
        FETCH:
          case (step_q)
            T0: if (run) {IncPC, MARin, PCin} = '1;
            T1: {Read, read_mem, MDRin} = '1;
            T2: {MDRout, IRin} = '1;
            default: ;
          endcase
        EXEC:
          case (step_q)
            T3: begin
              if (is_ld || is_ldi || is_st) {Grb, BAout, Yin} = '1;
              if (is_r || is_imm) {Grb, Rout, Yin} = '1;
              if (is_md) {Gra, Rout, Yin} = '1;
              if (is_nn) {Grb, Rout, alu_en, Zin} = '1;
              if (is_br) {Gra, Rout, CONin} = '1;
              if (op == 5'd20) {Gra, Rout, PCin} = '1;
              if (op == 5'd21) PCSave = 1'b1;
              if (op == 5'd22) {INout, Gra, Rin} = '1;
              if (op == 5'd23) {Gra, Rout, OUT_Portin} = '1;
              if (op == 5'd24) {LOout, Gra, Rin} = '1;
              if (op == 5'd25) {HIout, Gra, Rin} = '1;
            end
            T4: begin
              if (is_ld || is_ldi || is_st) {Cout, add_fix, Zin} = '1;
              if (is_r) {Grc, Rout, alu_en, Zin} = '1;
              if (is_imm) {Cout, alu_en, Zin} = '1;
              if (is_md) {Grb, Rout, alu_en, Zin} = '1;
              if (is_nn) {Zlowout, Gra, Rin} = '1;
              if (is_br) {PCout, Yin} = '1;
              if (op == 5'd21) {Gra, Rout, PCin} = '1;
            end
            T5: begin
              if (is_ld || is_st) {Zlowout, MARin} = '1;
              if (is_ldi || is_r || is_imm) {Zlowout, Gra, Rin} = '1;
              if (is_md) {Zlowout, LOin} = '1;
              if (is_br) {Cout, add_fix, Zin} = '1;
            end
            T6: begin
              if (is_ld) {Read, read_mem, MDRin} = '1;
              if (is_st) {Gra, Rout, MDRin} = '1;
              if (is_md) {Zhighout, HIin} = '1;
              if (is_br && CON_FF) {Zlowout, PCin} = '1;
            end
            T7: begin
              if (is_ld) {MDRout, Gra, Rin} = '1;
              if (is_st) write_mem = 1'b1;
            end
            default: ;
          endcase
      endcase
    // alu_en selects the opcode's own operation; add_fix is the address/offset add
    ADD = add_fix | (alu_en & (op == 5'd3 | op == 5'd12));
    SUB = alu_en & (op == 5'd4);
    AND = alu_en & (op == 5'd5 | op == 5'd13);
    OR = alu_en & (op == 5'd6 | op == 5'd14);
    ROR = alu_en & (op == 5'd7);
    ROL = alu_en & (op == 5'd8);
    SHR = alu_en & (op == 5'd9);
    SHRA = alu_en & (op == 5'd10);
    SHL = alu_en & (op == 5'd11);
    DIV = alu_en & (op == 5'd15);
    MUL = alu_en & (op == 5'd16);
    NEG = alu_en & (op == 5'd17);
    NOT = alu_en & (op == 5'd18);
  end
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: per-cycle control-word check of three sequencers (MEM_WAIT 0, 2, 3) against an instruction-table model
module tb_control_sequencer;
  typedef logic [44:0] vec_t;
  localparam vec_t HIOUT = 45'd1 << 0, LOOUT = 45'd1 << 1, ZHIGH = 45'd1 << 2, ZLOW = 45'd1 << 3;
  localparam vec_t PCOUT = 45'd1 << 4, MDROUT = 45'd1 << 5, INOUT = 45'd1 << 6, COUT = 45'd1 << 7;
  localparam vec_t GRA = 45'd1 << 9, GRB = 45'd1 << 10, GRC = 45'd1 << 11;
  localparam vec_t RIN = 45'd1 << 12, ROUT = 45'd1 << 13, BAOUT = 45'd1 << 14, PCSAVE = 45'd1 << 15;
  localparam vec_t HIIN = 45'd1 << 16, LOIN = 45'd1 << 17, PCIN = 45'd1 << 18, IRIN = 45'd1 << 19;
  localparam vec_t ZIN = 45'd1 << 20, YIN = 45'd1 << 21, MARIN = 45'd1 << 22, MDRIN = 45'd1 << 23;
  localparam vec_t CONIN = 45'd1 << 24, OUTP = 45'd1 << 25, INCPC = 45'd1 << 26;
  localparam vec_t ADD = 45'd1 << 27, SUB = 45'd1 << 28, AND = 45'd1 << 29, OR = 45'd1 << 30;
  localparam vec_t SHR = 45'd1 << 31, SHRA = 45'd1 << 32, SHL = 45'd1 << 33, ROR = 45'd1 << 34;
  localparam vec_t ROL = 45'd1 << 35, MUL = 45'd1 << 36, DIV = 45'd1 << 37, NEG = 45'd1 << 38;
  localparam vec_t NOT = 45'd1 << 39, READ = 45'd1 << 40, RDMEM = 45'd1 << 41, WRMEM = 45'd1 << 42;
  localparam vec_t CONRST = 45'd1 << 43, HALTED = 45'd1 << 44;
  logic clk = 1'b0;
  logic rst_n [3];
  logic run [3];
  logic [31:0] ir [3];
  logic cf [3];
  wire [44:0] o [3];
  int errors = 0, checks = 0;
  vec_t q[$];
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    control_sequencer #(.MEM_WAIT(g == 0 ? 0 : g + 1), .STEP_W(4)) dut (
      .clk(clk), .reset(rst_n[g]), .run(run[g]), .ir(ir[g]), .CON_FF(cf[g]),
      .HIout(o[g][0]), .LOout(o[g][1]), .Zhighout(o[g][2]), .Zlowout(o[g][3]),
      .PCout(o[g][4]), .MDRout(o[g][5]), .INout(o[g][6]), .Cout(o[g][7]), .MARout(o[g][8]),
      .Gra(o[g][9]), .Grb(o[g][10]), .Grc(o[g][11]), .Rin(o[g][12]), .Rout(o[g][13]),
      .BAout(o[g][14]), .PCSave(o[g][15]), .HIin(o[g][16]), .LOin(o[g][17]), .PCin(o[g][18]),
      .IRin(o[g][19]), .Zin(o[g][20]), .Yin(o[g][21]), .MARin(o[g][22]), .MDRin(o[g][23]),
      .CONin(o[g][24]), .OUT_Portin(o[g][25]), .IncPC(o[g][26]),
      .ADD(o[g][27]), .SUB(o[g][28]), .AND(o[g][29]), .OR(o[g][30]), .SHR(o[g][31]),
      .SHRA(o[g][32]), .SHL(o[g][33]), .ROR(o[g][34]), .ROL(o[g][35]), .MUL(o[g][36]),
      .DIV(o[g][37]), .NEG(o[g][38]), .NOT(o[g][39]), .Read(o[g][40]), .read_mem(o[g][41]),
      .write_mem(o[g][42]), .CON_RESET(o[g][43]), .halted(o[g][44])
    );
  end
  function automatic int wait_of(input int k);
    return k == 0 ? 0 : k + 1;
  endfunction
  function automatic vec_t alu(input int op);
    case (op)
      3, 12: return ADD;
      4: return SUB;
      5, 13: return AND;
      6, 14: return OR;
      7: return ROR;
      8: return ROL;
      9: return SHR;
      10: return SHRA;
      11: return SHL;
      15: return DIV;
      16: return MUL;
      17: return NEG;
      18: return NOT;
      default: return '0;
    endcase
  endfunction
  function automatic int cpi(input int op, input int w);
    int base;
    case (op)
      0, 2: base = 8;
      1, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14: base = 6;
      15, 16, 19: base = 7;
      17, 18, 21: base = 5;
      20, 22, 23, 24, 25: base = 4;
      default: base = 3;
    endcase
    return base + ((op == 0 || op == 2) ? 2 : 1) * w;
  endfunction
  task automatic push(input vec_t v, input int n);
    repeat (n) q.push_back(v);
  endtask
  task automatic build(input int op, input int w, input bit c);
    vec_t rd = READ | RDMEM | MDRIN;
    q.delete();
    push(INCPC | MARIN | PCIN, 1);
    push(rd, w + 1);
    push(MDROUT | IRIN, 1);
    if (op <= 2) begin push(GRB | BAOUT | YIN, 1); push(COUT | ADD | ZIN, 1); end
    if (op == 0 || op == 2) push(ZLOW | MARIN, 1);
    if (op == 0) begin push(rd, w + 1); push(MDROUT | GRA | RIN, 1); end
    if (op == 1) push(ZLOW | GRA | RIN, 1);
    if (op == 2) begin push(GRA | ROUT | MDRIN, 1); push(WRMEM, w + 1); end
    if (op >= 3 && op <= 14) begin
      push(GRB | ROUT | YIN, 1);
      push((op <= 11 ? GRC | ROUT : COUT) | alu(op) | ZIN, 1);
      push(ZLOW | GRA | RIN, 1);
    end
    if (op == 15 || op == 16) begin
      push(GRA | ROUT | YIN, 1); push(GRB | ROUT | alu(op) | ZIN, 1);
      push(ZLOW | LOIN, 1); push(ZHIGH | HIIN, 1);
    end
    if (op == 17 || op == 18) begin push(GRB | ROUT | alu(op) | ZIN, 1); push(ZLOW | GRA | RIN, 1); end
    if (op == 19) begin
      push(GRA | ROUT | CONIN, 1); push(PCOUT | YIN, 1); push(COUT | ADD | ZIN, 1);
      push(c ? ZLOW | PCIN : '0, 1);
    end
    if (op == 20) push(GRA | ROUT | PCIN, 1);
    if (op == 21) begin push(PCSAVE, 1); push(GRA | ROUT | PCIN, 1); end
    if (op == 22) push(INOUT | GRA | RIN, 1);
    if (op == 23) push(GRA | ROUT | OUTP, 1);
    if (op == 24) push(LOOUT | GRA | RIN, 1);
    if (op == 25) push(HIOUT | GRA | RIN, 1);
  endtask
  task automatic do_reset(input int k);
    @(negedge clk);
    rst_n[k] = 1'b0;
    run[k] = 1'b1;
    @(negedge clk);
    rst_n[k] = 1'b1;
    @(negedge clk);
  endtask
  task automatic test_reset;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (o[k] !== '0) begin errors++; $display("FAIL reset_held k=%0d got=%h exp=0", k, o[k]); end
      end
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      rst_n[k] = 1'b1;
      #1;
      checks++;
      if (o[k] !== CONRST) begin errors++; $display("FAIL reset_con k=%0d got=%h exp=%h", k, o[k], CONRST); end
      @(negedge clk);
      #1;
      checks++;
      if (o[k] !== (INCPC | MARIN | PCIN)) begin
        errors++; $display("FAIL reset_t0 k=%0d got=%h exp=%h", k, o[k], INCPC | MARIN | PCIN);
      end
    end
  endtask
  task automatic test_directed(input int k);
    int ops [12] = '{0, 1, 2, 19, 19, 16, 15, 21, 17, 25, 26, 30};
    do_reset(k);
    for (int n = 0; n < 12; n++) begin
      int r = $urandom();
      ir[k] = {5'(ops[n]), r[26:0]};
      cf[k] = n == 4;
      build(ops[n], wait_of(k), n == 4);
      for (int i = 0; i < q.size(); i++) begin
        if (i != 0) @(negedge clk);
        #1;
        checks++;
        if (o[k] !== q[i]) begin
          errors++; $display("FAIL directed k=%0d op=%0d cyc=%0d got=%h exp=%h", k, ops[n], i, o[k], q[i]);
        end
      end
      @(negedge clk);
    end
  endtask
  task automatic test_cpi(input int k);
    do_reset(k);
    for (int n = 0; n < 28; n++) begin
      int c = 0;
      int code = n == 27 ? 29 : n;
      ir[k] = {5'(code), 27'd0};
      cf[k] = 1'b1;
      do begin @(negedge clk); #1; c++; end while ((o[k] & INCPC) == '0 && c < 64);
      checks++;
      if (c != cpi(code, wait_of(k))) begin
        errors++; $display("FAIL cpi k=%0d op=%0d got=%0d exp=%0d", k, code, c, cpi(code, wait_of(k)));
      end
    end
  endtask
  task automatic test_run_gate(input int k);
    do_reset(k);
    ir[k] = 32'h00800005;
    build(0, wait_of(k), 1'b0);
    for (int i = 0; i < q.size(); i++) begin
      if (i != 0) @(negedge clk);
      #1;
      checks++;
      if (o[k] !== q[i]) begin errors++; $display("FAIL run_drop k=%0d cyc=%0d got=%h exp=%h", k, i, o[k], q[i]); end
      if (i == 1) run[k] = 1'b0;
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      checks++;
      if (o[k] !== '0) begin errors++; $display("FAIL stall k=%0d cyc=%0d got=%h exp=0", k, c, o[k]); end
    end
    ir[k] = {5'd20, 27'h1234};
    run[k] = 1'b1;
    build(20, wait_of(k), 1'b0);
    for (int i = 0; i < q.size(); i++) begin
      if (i != 0) @(negedge clk);
      #1;
      checks++;
      if (o[k] !== q[i]) begin errors++; $display("FAIL resume k=%0d cyc=%0d got=%h exp=%h", k, i, o[k], q[i]); end
    end
    @(negedge clk);
  endtask
  task automatic test_halt(input int k);
    do_reset(k);
    ir[k] = {5'd27, 27'd0};
    build(27, wait_of(k), 1'b0);
    for (int i = 0; i < q.size(); i++) begin
      if (i != 0) @(negedge clk);
      #1;
      checks++;
      if (o[k] !== q[i]) begin errors++; $display("FAIL halt_fetch k=%0d cyc=%0d got=%h exp=%h", k, i, o[k], q[i]); end
    end
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      run[k] = 1'($urandom_range(0, 1));
      ir[k] = $urandom();
      #1;
      checks++;
      if (o[k] !== HALTED) begin errors++; $display("FAIL halted k=%0d cyc=%0d got=%h exp=%h", k, c, o[k], HALTED); end
    end
    run[k] = 1'b1;
  endtask
  task automatic test_reset_mid(input int k);
    do_reset(k);
    ir[k] = {5'd2, 27'h0abcdef};
    build(2, wait_of(k), 1'b0);
    for (int i = 0; i < 12; i++) begin
      if (i != 0) @(negedge clk);
      #1;
      checks++;
      if (o[k] !== q[i]) begin errors++; $display("FAIL st_wait k=%0d cyc=%0d got=%h exp=%h", k, i, o[k], q[i]); end
    end
    #2;
    rst_n[k] = 1'b0;
    #1;
    checks++;
    if (o[k] !== '0) begin errors++; $display("FAIL async_reset k=%0d got=%h exp=0", k, o[k]); end
    @(negedge clk);
    #1;
    checks++;
    if (o[k] !== '0) begin errors++; $display("FAIL reset_hold k=%0d got=%h exp=0", k, o[k]); end
    @(negedge clk);
    rst_n[k] = 1'b1;
    #1;
    checks++;
    if (o[k] !== CONRST) begin errors++; $display("FAIL rerelease_con k=%0d got=%h exp=%h", k, o[k], CONRST); end
    @(negedge clk);
    #1;
    checks++;
    if (o[k] !== (INCPC | MARIN | PCIN)) begin
      errors++; $display("FAIL rerelease_t0 k=%0d got=%h exp=%h", k, o[k], INCPC | MARIN | PCIN);
    end
  endtask
  task automatic test_random(input int k, input int count);
    do_reset(k);
    for (int n = 0; n < count; n++) begin
      int op;
      int r = $urandom();
      do op = $urandom_range(0, 31); while (op == 27);
      ir[k] = {5'(op), r[26:0]};
      cf[k] = r[31];
      build(op, wait_of(k), r[31]);
      for (int i = 0; i < q.size(); i++) begin
        if (i != 0) @(negedge clk);
        #1;
        checks++;
        if (o[k] !== q[i]) begin
          errors++; $display("FAIL random k=%0d op=%0d cyc=%0d got=%h exp=%h", k, op, i, o[k], q[i]);
        end
      end
      @(negedge clk);
    end
  endtask
  initial begin
    for (int k = 0; k < 3; k++) begin
      rst_n[k] = 1'b1;
      run[k] = 1'b1;
      ir[k] = '0;
      cf[k] = 1'b0;
    end
    #2;
    for (int k = 0; k < 3; k++) rst_n[k] = 1'b0;
    test_reset();
    for (int k = 0; k < 3; k++) test_directed(k);
    for (int k = 0; k < 3; k++) test_cpi(k);
    test_run_gate(0);
    test_halt(1);
    test_reset_mid(2);
    for (int k = 0; k < 3; k++) test_random(k, 30);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal;
  end
endmodule
